// File: rtl/m_frame_encoder.sv
// rtl/m_frame_encoder.sv - serialises beep parameters into an 18-byte framed byte stream
//
// Purpose:
//   On i_start, latches the beep payload and sends the frame
//   AA 55 A5 5A | period[31:0] | high[31:0] | num[15:0] | CC 33 C3 3C
//   one byte at a time to a byte transmitter. The next byte is issued after
//   the transmitter reports i_tx_done for the current one.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_start        frame request, only honoured while idle
//   i_beep_period  32-bit period payload
//   i_beep_high    32-bit high-time payload
//   i_beep_num     16-bit count payload
//   i_tx_done      byte-finished pulse from the transmitter
//   o_tx_en        one-cycle byte strobe
//   o_tx_data      byte to send, held until the next strobe
//   o_busy         frame in progress
//   o_done         one-cycle pulse after the last byte completes
//   o_err          one-cycle pulse on timeout abort
//
// Configuration:
//   M_ENCODER_TIMEOUT_EN - when defined, a byte that is not acknowledged
//   within TIMEOUT_CYCLES cycles aborts the frame with o_err.

module m_frame_encoder #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_beep_period,
    input  logic [31:0] i_beep_high,
    input  logic [15:0] i_beep_num,
    input  logic        i_tx_done,
    output logic        o_tx_en,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'd17;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] period_q, period_d;
    logic [31:0] high_q, high_d;
    logic [15:0] num_q, num_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef M_ENCODER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    function automatic logic [7:0] frame_byte(
        input logic [4:0]  idx,
        input logic [31:0] per,
        input logic [31:0] hi,
        input logic [15:0] num
    );
        case (idx)
            5'd0:    frame_byte = 8'hAA;
            5'd1:    frame_byte = 8'h55;
            5'd2:    frame_byte = 8'hA5;
            5'd3:    frame_byte = 8'h5A;
            5'd4:    frame_byte = per[31:24];
            5'd5:    frame_byte = per[23:16];
            5'd6:    frame_byte = per[15:8];
            5'd7:    frame_byte = per[7:0];
            5'd8:    frame_byte = hi[31:24];
            5'd9:    frame_byte = hi[23:16];
            5'd10:   frame_byte = hi[15:8];
            5'd11:   frame_byte = hi[7:0];
            5'd12:   frame_byte = num[15:8];
            5'd13:   frame_byte = num[7:0];
            5'd14:   frame_byte = 8'hCC;
            5'd15:   frame_byte = 8'h33;
            5'd16:   frame_byte = 8'hC3;
            5'd17:   frame_byte = 8'h3C;
            default: frame_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        period_d  = period_q;
        high_d    = high_q;
        num_d     = num_q;
        tx_data_d = tx_data_q;
`ifdef M_ENCODER_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    period_d = i_beep_period;
                    high_d   = i_beep_high;
                    num_d    = i_beep_num;
                    idx_d    = 5'd0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
`ifdef M_ENCODER_TIMEOUT_EN
                cnt_d   = 16'd0;
`endif
            end
            ST_WAIT: begin
                // An acknowledge in the same cycle as the timeout still wins.
                if (i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_SEND;
                    end
                end
`ifdef M_ENCODER_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies
        // line up with the state they belong to.
        tx_en_d = (state_d == ST_SEND);
        if (tx_en_d) begin
            tx_data_d = frame_byte(idx_d, period_d, high_d, num_d);
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 5'd0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef M_ENCODER_TIMEOUT_EN
            cnt_q     <= 16'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef M_ENCODER_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Payload holding registers carry no reset; they are always loaded
    // before any byte that depends on them is issued.
    always_ff @(posedge i_clk) begin
        period_q <= period_d;
        high_q   <= high_d;
        num_q    <= num_d;
    end

    assign o_tx_en   = tx_en_q;
    assign o_tx_data = tx_data_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
`ifdef M_ENCODER_TIMEOUT_EN
    assign o_err     = err_q;
`else
    assign o_err     = 1'b0;
`endif

endmodule
